user_io_ctrl: RTL
=================

# user_io_ctrl

Parametrised Wishbone-controlled user I/O controller sitting between the Caravel wrapper pads and the eFPGA/CPU fabric. Each of `NUM_IO` pad channels is independently owned either by the fabric (pass-through) or by software-visible registers. Pad inputs are synchronised, edge-detected and mapped onto the `user_irq` lines. It supersedes fixed, hard-wired pad-to-fabric connections with run-time mux, direction and interrupt control.

## Interface
Parameters:
- `NUM_IO`, 38: pad channels, 1..256; `NB = ceil(NUM_IO/32)` register banks.
- `NUM_IRQ`, 3: user_irq lines, 1..32.
- `BASE_ADDR`, 32'h3000_0000: Wishbone base address; bits [7:0] must be 0.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic controls.
- `wbs_sel_i` in 4: byte enables.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_dat_o` out 32: read data.
- `wbs_ack_o` out 1: transfer acknowledge.
- `io_in` in NUM_IO: pad inputs.
- `io_out` out NUM_IO: pad outputs.
- `io_oeb` out NUM_IO: pad output enables, active-low.
- `fab_in` out NUM_IO: pad inputs to fabric, raw and combinational.
- `fab_out` in NUM_IO: fabric pad-drive data.
- `fab_oeb` in NUM_IO: fabric output enables.
- `user_irq` out NUM_IRQ: level interrupts.

## Operation
- Address hit: `wbs_adr_i[31:8] == BASE_ADDR[31:8]`. A miss gets no ack, because another slave owns that range.
- Register map, byte offset = region base + 4*bank, bank < NB:
  - 0x00 DOUT: RW.
  - 0x20 OEB: RW, reset all 1.
  - 0x40 MODE: RW; 1 means the fabric owns the channel.
  - 0x60 DIN: RO, synchronised value.
  - 0x80 IRQ_EN: RW.
  - 0xA0 IRQ_STAT: W1C.
  - 0xC0 EDGE: RW; 0 = rising, 1 = falling.
- Unused bits (channel index ≥ NUM_IO) read 0 and ignore writes. Banks ≥ NB and offsets ≥ 0xE0 read 0, ignore writes, and still ack.
- Writes honour `wbs_sel_i` per byte. Writes to DIN have no effect.
- Per channel i:
  - `io_out[i] = MODE[i] ? fab_out[i] : DOUT[i]`
  - `io_oeb[i] = MODE[i] ? fab_oeb[i] : OEB[i]`
- Input path: `io_in` passes through a SYNC_STAGES flop chain, giving DIN. An edge is the selected transition between DIN and its one-cycle-delayed copy.
- STAT[i] is set on a selected edge when EN[i]=1. It is cleared by writing 1. If a set and a clear hit the same cycle, the set wins.
- `user_irq[k]` = OR over channels i with `i % NUM_IRQ == k` of `STAT[i] & EN[i]`.
- Bus FSM:
  - IDLE → ACK when `cyc & stb & hit`.
  - ACK → IDLE unconditionally, so ack is one cycle high and back-to-back transfers cost 2 cycles each.
- Reset values: all registers 0 except OEB = all 1; FSM IDLE. Outputs then are `wbs_ack_o` = 0, `wbs_dat_o` = 0, `io_out` = 0 (when MODE = 0), `io_oeb` = all 1, `user_irq` = 0.
- Reset asserted mid-transfer: ack drops immediately (asynchronously) and no register write commits.

## Timing
- Ack rises on the first edge after `cyc & stb & hit` is sampled.
- The write commits on that same edge, so `io_out`/`io_oeb` reflect it in the ack cycle.
- `wbs_dat_o` is registered alongside ack and is 0 whenever ack = 0.
- Pad edge to DIN readable: SYNC_STAGES cycles. STAT and `user_irq` assert one cycle later; `user_irq` is combinational from STAT/EN.
- `fab_in` has zero latency. The mux paths (`fab_out`/`fab_oeb` → `io_out`/`io_oeb`) are combinational.

## Structure
- Shared package `user_io_pkg` holds:
  - region offsets (`OFF_DOUT`..`OFF_EDGE`);
  - function `nbanks(n)`;
  - FSM state enum `{S_IDLE, S_ACK}`.
- Sub-module `user_io_sync`: per-channel synchroniser, delayed copy and edge select, producing `din` and `edge_pulse`. Instantiate it NUM_IO times or vectorised.

## Test plan
- Reset: release `wb_rst_ni` → `io_oeb` = all 1, `io_out` = 0, `user_irq` = 0; every register read returns its reset value (OEB bank 1 reads 0x3F for NUM_IO=38).
- Register drive: write DOUT bank0 = 0xA5A5_A5A5 with sel=4'b0011, then OEB bank0 = 0 → `io_out[15:0]` = 0xA5A5 and `io_out[31:16]` = 0; `io_oeb[31:0]` = 0; ack lasts exactly 1 cycle.
- Fabric ownership: MODE bank1 = 0x3F with `fab_out[37:32]` = 6'h2A and `fab_oeb` = 0 → `io_out[37:32]` = 6'h2A; writing DOUT bank1 changes nothing on the pads.
- Interrupt, rising edge: EN[4] = 1, `io_in[4]` 0→1 → DIN bit 4 is set after 2 cycles and `user_irq[1]` rises 1 cycle later. Writing 0x10 to STAT clears it; a new edge coincident with the clear leaves it set.
- Falling edge and bank 1: EDGE[37] = 1, EN[37] = 1, `io_in[37]` 1→0 → `user_irq[1]` (37 % 3 = 1) asserts; a 0→1 transition does not assert it.
- Decode: an address outside BASE gets no ack within 4 cycles; offset 0xE0 acks with read 0; reset asserted during the ack cycle drops ack immediately and the write is lost.

Source files
------------

// File: rtl/user_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_io_pkg
// Description : Shared definitions for the user I/O controller: register
//               region offsets, bank-count helper and bus FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package user_io_pkg;

  // Region base offsets within the 256-byte slave window. Bits [7:5] select
  // the region, bits [4:2] select the 32-bit bank inside it.
  localparam logic [7:0] OFF_DOUT = 8'h00;
  localparam logic [7:0] OFF_OEB  = 8'h20;
  localparam logic [7:0] OFF_MODE = 8'h40;
  localparam logic [7:0] OFF_DIN  = 8'h60;
  localparam logic [7:0] OFF_EN   = 8'h80;
  localparam logic [7:0] OFF_STAT = 8'hA0;
  localparam logic [7:0] OFF_EDGE = 8'hC0;

  // Number of 32-bit register banks needed to cover n channels.
  function automatic int nbanks(input int n);
    return (n + 31) / 32;
  endfunction

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/user_io_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : user_io_ctrl_if
// Description : Wishbone classic slave bundle for the user I/O controller.
//               master : drives cyc/stb/we/sel/adr/dat_i, receives dat_o/ack
//               slave  : the opposite direction
// Revision    : 1.0 - initial release
// ============================================================================
interface user_io_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/user_io_sync.sv
`default_nettype none
// ============================================================================
// Module      : user_io_sync
// Description : One pad-input channel: SYNC_STAGES-deep synchroniser, a
//               one-cycle delayed copy and rising/falling edge select.
// Ports       : clk_i, rst_ni      - clock, async active-low reset
//               pad_i              - raw pad input
//               edge_sel_i         - 0 = rising, 1 = falling
//               din_o              - synchronised value
//               edge_pulse_o       - one-cycle pulse on the selected edge
// Revision    : 1.0 - initial release
// ============================================================================
module user_io_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  input  logic edge_sel_i,
  output logic din_o,
  output logic edge_pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign din_o        = sync_q[SYNC_STAGES-1];
  assign edge_pulse_o = edge_sel_i ? (prev_q & ~din_o) : (~prev_q & din_o);

endmodule
`default_nettype wire

// File: rtl/user_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : user_io_ctrl
// Description : Wishbone-controlled user I/O controller. Each pad channel is
//               owned by the fabric (MODE=1) or by DOUT/OEB registers. Pad
//               inputs are synchronised, edge detected and folded onto
//               user_irq lines (channel i -> line i % NUM_IRQ).
// Ports       : wb_clk_i, wb_rst_ni - clock, async active-low reset
//               wbs                 - Wishbone classic slave bundle
//               io_in/io_out/io_oeb - pad side
//               fab_in/fab_out/fab_oeb - fabric side
//               user_irq            - level interrupts
// Revision    : 1.0 - initial release
// ============================================================================
module user_io_ctrl
  import user_io_pkg::*;
#(
  parameter int          NUM_IO      = 38,
  parameter int          NUM_IRQ     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  user_io_ctrl_if.slave       wbs,
  input  logic [NUM_IO-1:0]   io_in,
  output logic [NUM_IO-1:0]   io_out,
  output logic [NUM_IO-1:0]   io_oeb,
  output logic [NUM_IO-1:0]   fab_in,
  input  logic [NUM_IO-1:0]   fab_out,
  input  logic [NUM_IO-1:0]   fab_oeb,
  output logic [NUM_IRQ-1:0]  user_irq
);

  localparam int NB = nbanks(NUM_IO);
  localparam int W  = NB * 32;

  localparam logic [0:0] ST_IDLE = S_IDLE;
  localparam logic [0:0] ST_ACK  = S_ACK;

  logic [0:0]        state_q, state_d;
  logic [31:0]       dat_q, dat_d;
  logic [NUM_IO-1:0] dout_q, dout_d;
  logic [NUM_IO-1:0] oeb_q, oeb_d;
  logic [NUM_IO-1:0] mode_q, mode_d;
  logic [NUM_IO-1:0] en_q, en_d;
  logic [NUM_IO-1:0] stat_q, stat_d;
  logic [NUM_IO-1:0] edge_q, edge_d;

  logic [NUM_IO-1:0] din;
  logic [NUM_IO-1:0] edge_pulse;

  logic              hit, req, wr;
  logic [2:0]        rgn, bank;
  logic [NUM_IO-1:0] wmask, wdata, clr;
  logic [NUM_IO-1:0] rd_vec;
  logic [W-1:0]      rd_pad;
  logic [31:0]       rdata;

  // --------------------------------------------------------------------------
  // Input path
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
    user_io_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk_i        (wb_clk_i),
      .rst_ni       (wb_rst_ni),
      .pad_i        (io_in[i]),
      .edge_sel_i   (edge_q[i]),
      .din_o        (din[i]),
      .edge_pulse_o (edge_pulse[i])
    );
  end

  assign fab_in = io_in;

  // --------------------------------------------------------------------------
  // Bus decode: a transfer is accepted only from IDLE, so the ACK cycle never
  // re-triggers while the master still holds stb.
  // --------------------------------------------------------------------------
  assign hit  = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req  = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit & (state_q == ST_IDLE);
  assign wr   = req & wbs.wbs_we_i;
  assign rgn  = wbs.wbs_adr_i[7:5];
  assign bank = wbs.wbs_adr_i[4:2];

  // Per-channel write mask and data; channels outside the addressed bank,
  // and banks beyond NB, simply never match.
  always_comb begin
    wmask = '0;
    wdata = '0;
    for (int ch = 0; ch < NUM_IO; ch++) begin
      wdata[ch] = wbs.wbs_dat_i[ch % 32];
      wmask[ch] = wr && (32'(bank) == ch / 32) && wbs.wbs_sel_i[(ch % 32) / 8];
    end
  end

  always_comb begin
    dout_d = dout_q;
    oeb_d  = oeb_q;
    mode_d = mode_q;
    en_d   = en_q;
    edge_d = edge_q;
    clr    = '0;
    case (rgn)
      OFF_DOUT[7:5]: dout_d = (dout_q & ~wmask) | (wdata & wmask);
      OFF_OEB[7:5]:  oeb_d  = (oeb_q  & ~wmask) | (wdata & wmask);
      OFF_MODE[7:5]: mode_d = (mode_q & ~wmask) | (wdata & wmask);
      OFF_EN[7:5]:   en_d   = (en_q   & ~wmask) | (wdata & wmask);
      OFF_STAT[7:5]: clr    = wdata & wmask;
      OFF_EDGE[7:5]: edge_d = (edge_q & ~wmask) | (wdata & wmask);
      default:       ;
    endcase
    // Set is applied after clear so a coincident edge wins.
    stat_d = (stat_q & ~clr) | (edge_pulse & en_q);
  end

  // --------------------------------------------------------------------------
  // Read mux: region select, zero-pad to a whole number of banks, bank select.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_vec = '0;
    case (rgn)
      OFF_DOUT[7:5]: rd_vec = dout_q;
      OFF_OEB[7:5]:  rd_vec = oeb_q;
      OFF_MODE[7:5]: rd_vec = mode_q;
      OFF_DIN[7:5]:  rd_vec = din;
      OFF_EN[7:5]:   rd_vec = en_q;
      OFF_STAT[7:5]: rd_vec = stat_q;
      OFF_EDGE[7:5]: rd_vec = edge_q;
      default:       rd_vec = '0;
    endcase
    rd_pad             = '0;
    rd_pad[NUM_IO-1:0] = rd_vec;
    rdata              = '0;
    for (int b = 0; b < NB; b++) begin
      if (32'(bank) == b) rdata = rd_pad[b*32 +: 32];
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_IDLE && req) state_d = ST_ACK;
    dat_d = (req && !wbs.wbs_we_i) ? rdata : 32'h0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      dout_q  <= '0;
      oeb_q   <= '1;
      mode_q  <= '0;
      en_q    <= '0;
      stat_q  <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      dout_q  <= dout_d;
      oeb_q   <= oeb_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      edge_q  <= edge_d;
    end
  end

  assign wbs.wbs_ack_o = (state_q == ST_ACK);
  assign wbs.wbs_dat_o = dat_q;

  // --------------------------------------------------------------------------
  // Pad output mux and interrupt folding
  // --------------------------------------------------------------------------
  assign io_out = (mode_q & fab_out) | (~mode_q & dout_q);
  assign io_oeb = (mode_q & fab_oeb) | (~mode_q & oeb_q);

  always_comb begin
    user_irq = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      for (int i = 0; i < NUM_IO; i++) begin
        if ((i % NUM_IRQ) == k) user_irq[k] = user_irq[k] | (stat_q[i] & en_q[i]);
      end
    end
  end

endmodule
`default_nettype wire
